// File: rtl/encoder_channel_ctrl.sv
// Routes one rotary encoder to num_ch saturating channel registers; a select
// button steps the focus and an optional idle timeout returns focus to channel 0.
//
// state | meaning
// IDLE  | button released, a rising edge advances the focus
// HELD  | button held, further focus steps suppressed until release
module encoder_channel_ctrl #(
    parameter int width        = 8,
    parameter int num_ch       = 3,
    parameter int idle_timeout = 0
) (
    input  logic                    clk,
    input  logic                    reset,
    input  logic [width-1:0]        enc_value,
    input  logic                    sel_button,
    output logic [2:0]              ch_sel,
    output logic [num_ch*width-1:0] ch_values,
    output logic                    update
);

    typedef enum logic {IDLE, HELD} sel_state_t;

    localparam logic [23:0]            TIMEOUT = 24'(idle_timeout);
    localparam logic signed [width+1:0] CH_MAX  = {2'b00, {width{1'b1}}};

    sel_state_t         sel_state;
    logic [width-1:0]   enc_prev;
    logic               btn_prev;
    logic [width-1:0]   delta_q;
    logic [2:0]         delta_ch;
    logic [width-1:0]   ch_mem [num_ch];
    logic [23:0]        idle_cnt;
    logic               idle_fired;

    logic [width-1:0]   delta_raw;
    logic               sel_edge;
    logic               activity;
    logic               expire;
    logic [width-1:0]   cur_val;
    logic [width-1:0]   next_val;
    logic signed [width+1:0] sum;

    assign delta_raw = enc_value - enc_prev;
    assign sel_edge  = (sel_state == IDLE) && sel_button && !btn_prev;
    assign activity  = (delta_raw != '0) || sel_edge;
    assign expire    = (idle_timeout != 0) && (idle_cnt == TIMEOUT) && !idle_fired && !activity;

    // The delta is registered together with the channel focused when it was
    // sampled, so a focus step on the same edge cannot redirect it.
    always_comb begin
        cur_val = '0;
        for (int k = 0; k < num_ch; k++) begin
            if (delta_ch == 3'(k)) cur_val = ch_mem[k];
        end
        sum = $signed({2'b00, cur_val}) + $signed({{2{delta_q[width-1]}}, delta_q});
        if (sum[width+1])
            next_val = '0;
        else if (sum > CH_MAX)
            next_val = '1;
        else
            next_val = sum[width-1:0];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sel_state  <= IDLE;
            enc_prev   <= enc_value;
            btn_prev   <= sel_button;
            delta_q    <= '0;
            delta_ch   <= '0;
            ch_sel     <= '0;
            update     <= 1'b0;
            idle_cnt   <= '0;
            idle_fired <= 1'b0;
            for (int k = 0; k < num_ch; k++) ch_mem[k] <= '0;
        end else begin
            enc_prev <= enc_value;
            btn_prev <= sel_button;
            delta_q  <= delta_raw;
            delta_ch <= ch_sel;
            update   <= 1'b0;

            if (delta_q != '0) begin
                for (int k = 0; k < num_ch; k++) begin
                    if (delta_ch == 3'(k)) ch_mem[k] <= next_val;
                end
                update <= (next_val != cur_val);
            end

            case (sel_state)
                IDLE: if (sel_edge) sel_state <= HELD;
                HELD: if (!sel_button) sel_state <= IDLE;
                default: sel_state <= IDLE;
            endcase

            if (sel_edge)
                ch_sel <= (ch_sel == 3'(num_ch - 1)) ? 3'd0 : ch_sel + 3'd1;
            else if (expire)
                ch_sel <= '0;

            // Counter saturates at the timeout; idle_fired limits the forced
            // return to one per idle period.
            if (activity) begin
                idle_cnt   <= '0;
                idle_fired <= 1'b0;
            end else begin
                if (idle_cnt < TIMEOUT) idle_cnt <= idle_cnt + 24'd1;
                if (expire) idle_fired <= 1'b1;
            end
        end
    end

    for (genvar g = 0; g < num_ch; g++) begin : g_out
        assign ch_values[g*width +: width] = ch_mem[g];
    end

endmodule

// File: tb/tb_encoder_channel_ctrl.sv
// Directed bench for encoder_channel_ctrl: saturation, wrap, latency, focus
// stepping, mid-operation reset and the idle timeout.
module tb_encoder_channel_ctrl;

    logic        clk = 1'b0;
    logic        reset;
    logic [7:0]  enc_value, enc_to;
    logic        sel_button, sel_to;
    logic [2:0]  ch_sel, ch_sel_to;
    logic [23:0] ch_values, ch_values_to;
    logic        update, update_to;

    int errors = 0;
    int checks = 0;

    always #5 clk = ~clk;

    encoder_channel_ctrl #(.width(8), .num_ch(3), .idle_timeout(0)) dut (
        .clk(clk), .reset(reset), .enc_value(enc_value), .sel_button(sel_button),
        .ch_sel(ch_sel), .ch_values(ch_values), .update(update)
    );

    encoder_channel_ctrl #(.width(8), .num_ch(3), .idle_timeout(100)) dut_to (
        .clk(clk), .reset(reset), .enc_value(enc_to), .sel_button(sel_to),
        .ch_sel(ch_sel_to), .ch_values(ch_values_to), .update(update_to)
    );

    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Drive a new count, check ch0 and update two edges later, then update low.
    task automatic apply_enc(input logic [7:0] v, input logic [7:0] exp_ch0,
                             input logic exp_upd, input string tag);
        enc_value = v;
        step(2);
        chk(tag, 32'(ch_values[7:0]), 32'(exp_ch0));
        chk({tag, "_upd"}, 32'(update), 32'(exp_upd));
        step(1);
        chk({tag, "_upd_off"}, 32'(update), 32'd0);
    endtask

    task automatic press(input int hold, input int gap);
        sel_button = 1'b1;
        step(hold);
        sel_button = 1'b0;
        step(gap);
    endtask

    initial begin
        logic [2:0] exp_sel [2];
        exp_sel[0] = 3'd2;
        exp_sel[1] = 3'd0;

        reset = 1'b1; enc_value = 8'h37; sel_button = 1'b0; enc_to = 8'h00; sel_to = 1'b0;
        step(3);
        reset = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step(1);
            chk("rst_upd_quiet", 32'(update), 32'd0);
        end
        chk("rst_values", 32'(ch_values), 32'd0);
        chk("rst_sel", 32'(ch_sel), 32'd0);

        apply_enc(8'h00, 8'd0, 1'b0, "to_zero");

        enc_value = 8'h05;
        step(1);
        chk("lat_early", 32'(ch_values[7:0]), 32'd0);
        step(1);
        chk("up5", 32'(ch_values[7:0]), 32'd5);
        chk("up5_upd", 32'(update), 32'd1);
        step(1);
        chk("up5_upd_off", 32'(update), 32'd0);
        chk("up5_others", 32'(ch_values[23:8]), 32'd0);

        apply_enc(8'h03, 8'd3,   1'b1, "dn2");
        apply_enc(8'hF9, 8'd0,   1'b1, "dn10_sat");
        apply_enc(8'hF8, 8'd0,   1'b0, "dn1_rail");
        apply_enc(8'h75, 8'd125, 1'b1, "up125");
        apply_enc(8'hF2, 8'd250, 1'b1, "up125b");
        apply_enc(8'hFC, 8'd255, 1'b1, "up10_sat");
        apply_enc(8'hFD, 8'd255, 1'b0, "up1_rail");
        apply_enc(8'h7D, 8'd127, 1'b1, "half_neg");
        apply_enc(8'hFF, 8'd1,   1'b1, "dn126");
        apply_enc(8'hF8, 8'd0,   1'b1, "dn7_sat");
        apply_enc(8'hFF, 8'd7,   1'b1, "up7");
        apply_enc(8'h00, 8'd8,   1'b1, "wrap_up");
        apply_enc(8'hFF, 8'd7,   1'b1, "wrap_dn");

        // +4 delta on the same edge as the first press lands in ch0
        enc_value = 8'h03;
        sel_button = 1'b1;
        step(2);
        chk("press1_sel", 32'(ch_sel), 32'd1);
        chk("press1_ch0", 32'(ch_values[7:0]), 32'd11);
        chk("press1_ch1", 32'(ch_values[15:8]), 32'd0);
        step(18);
        chk("press1_held", 32'(ch_sel), 32'd1);
        sel_button = 1'b0;
        step(5);
        chk("press1_rel", 32'(ch_sel), 32'd1);
        for (int i = 0; i < 2; i++) begin
            press(20, 5);
            chk($sformatf("press%0d_sel", i + 2), 32'(ch_sel), 32'(exp_sel[i]));
        end

        press(3, 3);
        enc_value = 8'h06;
        step(3);
        chk("ch1_delta", 32'(ch_values[15:8]), 32'd3);
        chk("ch1_ch0_kept", 32'(ch_values[7:0]), 32'd11);

        // Reset with a pending delta and a held button
        sel_button = 1'b1;
        enc_value = 8'h10;
        step(1);
        reset = 1'b1;
        step(1);
        chk("midrst_values", 32'(ch_values), 32'd0);
        reset = 1'b0;
        step(3);
        chk("midrst_sel", 32'(ch_sel), 32'd0);
        chk("midrst_values_after", 32'(ch_values), 32'd0);
        chk("midrst_upd", 32'(update), 32'd0);
        sel_button = 1'b0;
        step(2);
        sel_button = 1'b1;
        step(2);
        chk("midrst_press", 32'(ch_sel), 32'd1);
        sel_button = 1'b0;
        step(2);

        // Idle timeout, undisturbed
        sel_to = 1'b1; step(1); sel_to = 1'b0; step(2);
        sel_to = 1'b1; step(1); sel_to = 1'b0;
        chk("to_sel2", 32'(ch_sel_to), 32'd2);
        step(100);
        chk("to_before", 32'(ch_sel_to), 32'd2);
        step(1);
        chk("to_expire", 32'(ch_sel_to), 32'd0);

        // Activity at idle cycle 99 restarts the count
        sel_to = 1'b1; step(1); sel_to = 1'b0; step(2);
        sel_to = 1'b1; step(1); sel_to = 1'b0;
        step(98);
        enc_to = 8'h01;
        step(3);
        chk("to_restart", 32'(ch_sel_to), 32'd2);
        chk("to_ch2", 32'(ch_values_to[23:16]), 32'd1);
        step(98);
        chk("to_restart_before", 32'(ch_sel_to), 32'd2);
        step(1);
        chk("to_restart_expire", 32'(ch_sel_to), 32'd0);
        chk("to_ch2_kept", 32'(ch_values_to[23:16]), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
